apu_core_dispatcher: RTL and testbench
======================================

APU_CORE_DISPATCHER -- requirements
Module: apu_core_dispatcher

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- NUSFLAGS, 8: width of upstream status flags returned with a result.
- WRESULT, 32: result data width.
- WADDR, 6: register-file write address width.
REQ-002 Ports (name, direction, width, meaning), one per line:
- clk_i, in, 1: the single clock.
- rst_i, in, 1: reset, synchronous, active-high.
- enable_i, in, 1: decode presents an APU op this cycle.
- waddr_i, in, WADDR: destination register of the presented op.
- read_regs_i, in, 3*WADDR: source register addresses, packed.
- read_regs_valid_i, in, 3: per-source valid.
- apu_req_o, out, 1: request to the shared APU interconnect.
- apu_gnt_i, in, 1: grant from the interconnect.
- apu_rvalid_i, in, 1: result valid from the interconnect.
- apu_rdata_i, in, WRESULT: result data.
- apu_rflags_i, in, NUSFLAGS: result status flags.
- stall_o, out, 1: decode must hold the op stable.
- result_valid_o, out, 1: writeback valid.
- result_waddr_o, out, WADDR: writeback address.
- result_o, out, WRESULT: writeback data.
- flags_o, out, NUSFLAGS: writeback flags.
- busy_o, out, 1: at least one op is in flight or in writeback.
- proto_err_o, out, 1: sticky protocol-error flag.

Function
REQ-003 The block SHALL track in-flight ops in an in-order FIFO of depth C_APU_MAX_OUTSTANDING (2), with one destination address per entry, plus an outstanding counter ranging 0..2.
REQ-004 A hazard SHALL exist when any valid source address, or waddr_i, equals an in-flight FIFO entry or result_waddr_o while result_valid_o is high.
REQ-005 apu_req_o SHALL equal enable_i AND NOT hazard AND NOT full; it is combinational, and no operand path passes through the block.
REQ-006 stall_o SHALL equal enable_i AND NOT (apu_req_o AND apu_gnt_i).
REQ-007 On apu_req_o AND apu_gnt_i, waddr_i SHALL be pushed and the counter incremented.
REQ-008 On apu_rvalid_i with counter above 0, the head SHALL be popped and the counter decremented.
REQ-009 When the push of REQ-007 and the pop of REQ-008 occur in the same cycle, the counter SHALL remain unchanged and both FIFO operations SHALL occur.
REQ-010 Writeback SHALL be registered with 1-cycle latency: the cycle after an accepted rvalid, result_valid_o=1 with the popped address, apu_rdata_i and apu_rflags_i; otherwise result_valid_o=0 and the data outputs hold their values.
REQ-011 apu_rvalid_i with counter=0 SHALL be ignored (no writeback produced) and SHALL set proto_err_o, which stays set until reset.
REQ-012 busy_o SHALL equal (counter != 0) OR result_valid_o.
REQ-013 FIFO pointers SHALL wrap modulo 2; full means counter=2.

Reset
REQ-014 While rst_i=1 at a clock edge, the block SHALL clear the counter, FIFO pointers, result_valid_o, result_waddr_o, result_o, flags_o and proto_err_o to 0.
REQ-015 Ops in flight at reset SHALL be discarded; rvalids arriving after reset with counter=0 SHALL follow REQ-011.

Configuration
REQ-016 With APU_DISPATCH_PERF_EN defined, the block SHALL add output perf_stall_cnt_o (16 bits), which increments on each cycle with stall_o=1, saturates at 16'hFFFF and resets to 0.
REQ-017 Without APU_DISPATCH_PERF_EN, the port and counter SHALL be absent and all other behaviour SHALL be identical.

Structure
REQ-018 C_APU_MAX_OUTSTANDING, together with the NUSFLAGS and WRESULT defaults, SHALL reside in apu_cluster_package.
REQ-019 The in-flight FIFO SHALL be the sub-module apu_dispatch_fifo; hazard compare, counter and writeback register SHALL stay in the top module.

Verification
REQ-020 Single op: enable_i=1, waddr_i=5, gnt same cycle, rvalid 3 cycles later with rdata=32'h3F800000 -> stall_o=0; one cycle after rvalid, result_valid_o=1, result_waddr_o=5, result_o=32'h3F800000.
REQ-021 Full: two ops granted to waddr 1 and 2, no rvalid, third op enable_i=1 -> apu_req_o=0, stall_o=1 until the first rvalid.
REQ-022 RAW hazard: op to waddr 7 in flight, new op with read_regs_i[0]=7 valid -> apu_req_o=0 through the writeback cycle; request issues the cycle after.
REQ-023 Simultaneous events: counter=1, gnt and rvalid in the same cycle -> counter stays 1, FIFO head advances, writeback address equals the older op.
REQ-024 Protocol error and reset: rvalid with counter=0 -> no writeback, proto_err_o=1; rst_i=1 -> proto_err_o=0 and busy_o=0 next cycle.
REQ-025 With APU_DISPATCH_PERF_EN defined: 5 stall cycles -> perf_stall_cnt_o=5; preloaded at 16'hFFFF -> remains 16'hFFFF.

Source files
------------

// File: rtl/apu_cluster_package.sv
// Shared constants for the APU cluster dispatch logic.
//   C_APU_MAX_OUTSTANDING : ops that may be in flight at once
//   C_APU_CNT_W           : width of the outstanding counter (0..C_APU_MAX_OUTSTANDING)
//   C_NUSFLAGS            : default width of the upstream status flags
//   C_WRESULT             : default result data width
package apu_cluster_package;

    localparam int C_APU_MAX_OUTSTANDING = 2;
    localparam int C_APU_CNT_W           = $clog2(C_APU_MAX_OUTSTANDING + 1);
    localparam int C_NUSFLAGS            = 8;
    localparam int C_WRESULT             = 32;

endpackage

// File: rtl/apu_dispatch_fifo.sv
// In-order FIFO of destination register addresses for ops in flight on the
// APU interconnect. Every slot is visible so the top can run hazard compares.
// Ports:
//   clk_i, rst_i : clock, synchronous active-high reset
//   push_i       : store data_i at the tail
//   pop_i        : retire the head
//   data_i       : destination address to store
//   head_o       : address at the head (oldest op)
//   entries_o    : all slot addresses, packed, slot s at [s*WADDR +: WADDR]
//   valid_o      : per-slot occupied flags
module apu_dispatch_fifo #(
    parameter int DEPTH = 2,
    parameter int WADDR = 6
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   push_i,
    input  logic                   pop_i,
    input  logic [WADDR-1:0]       data_i,
    output logic [WADDR-1:0]       head_o,
    output logic [DEPTH*WADDR-1:0] entries_o,
    output logic [DEPTH-1:0]       valid_o
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WADDR-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            valid_o <= '0;
            for (int s = 0; s < DEPTH; s++) mem[s] <= '0;
        end else begin
            // Push into a full FIFO / pop from an empty one is prevented by the
            // top (request gated on full, pop gated on counter), so the two
            // never target the same slot in one cycle.
            if (push_i) begin
                mem[wr_ptr]     <= data_i;
                valid_o[wr_ptr] <= 1'b1;
                wr_ptr          <= next_ptr(wr_ptr);
            end
            if (pop_i) begin
                valid_o[rd_ptr] <= 1'b0;
                rd_ptr          <= next_ptr(rd_ptr);
            end
        end
    end

    always_comb begin
        entries_o = '0;
        for (int s = 0; s < DEPTH; s++) entries_o[s*WADDR +: WADDR] = mem[s];
    end

    assign head_o = mem[rd_ptr];

endmodule

// File: rtl/apu_core_dispatcher.sv
// Dispatches APU ops from decode onto the shared APU interconnect, blocks
// issue on register hazards against ops in flight or in writeback, and
// registers the returned result for writeback.
// Optional feature: define APU_DISPATCH_PERF_EN to add perf_stall_cnt_o, a
// saturating 16-bit count of stall cycles.
// Ports:
//   clk_i, rst_i          : clock, synchronous active-high reset
//   enable_i              : decode presents an APU op
//   waddr_i               : destination register of that op
//   read_regs_i           : three packed source addresses, src i at [i*WADDR +: WADDR]
//   read_regs_valid_i     : per-source valid
//   apu_req_o / apu_gnt_i : request/grant handshake with the interconnect
//   apu_rvalid_i, apu_rdata_i, apu_rflags_i : returned result
//   stall_o               : decode must hold the op
//   result_valid_o, result_waddr_o, result_o, flags_o : registered writeback
//   busy_o                : op in flight or in writeback
//   proto_err_o           : sticky, set by an rvalid with nothing outstanding
module apu_core_dispatcher
    import apu_cluster_package::*;
#(
    parameter int NUSFLAGS = C_NUSFLAGS,
    parameter int WRESULT  = C_WRESULT,
    parameter int WADDR    = 6
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 enable_i,
    input  logic [WADDR-1:0]     waddr_i,
    input  logic [3*WADDR-1:0]   read_regs_i,
    input  logic [2:0]           read_regs_valid_i,
    output logic                 apu_req_o,
    input  logic                 apu_gnt_i,
    input  logic                 apu_rvalid_i,
    input  logic [WRESULT-1:0]   apu_rdata_i,
    input  logic [NUSFLAGS-1:0]  apu_rflags_i,
    output logic                 stall_o,
    output logic                 result_valid_o,
    output logic [WADDR-1:0]     result_waddr_o,
    output logic [WRESULT-1:0]   result_o,
    output logic [NUSFLAGS-1:0]  flags_o,
    output logic                 busy_o,
    output logic                 proto_err_o
`ifdef APU_DISPATCH_PERF_EN
    ,
    output logic [15:0]          perf_stall_cnt_o
`endif
);

    localparam int DEPTH = C_APU_MAX_OUTSTANDING;
    localparam int CW    = C_APU_CNT_W;

    logic [CW-1:0]          cnt;
    logic [WADDR-1:0]       head_addr;
    logic [DEPTH*WADDR-1:0] slot_addr;
    logic [DEPTH-1:0]       slot_valid;
    logic                   hazard;
    logic                   full;
    logic                   push;
    logic                   pop;

    apu_dispatch_fifo #(
        .DEPTH (DEPTH),
        .WADDR (WADDR)
    ) u_fifo (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .push_i    (push),
        .pop_i     (pop),
        .data_i    (waddr_i),
        .head_o    (head_addr),
        .entries_o (slot_addr),
        .valid_o   (slot_valid)
    );

    // The destination is compared too (WAW): results must not retire out of
    // order into the same register.
    always_comb begin
        hazard = 1'b0;
        for (int s = 0; s < DEPTH; s++) begin
            if (slot_valid[s]) begin
                if (waddr_i == slot_addr[s*WADDR +: WADDR]) hazard = 1'b1;
                for (int r = 0; r < 3; r++) begin
                    if (read_regs_valid_i[r] &&
                        read_regs_i[r*WADDR +: WADDR] == slot_addr[s*WADDR +: WADDR])
                        hazard = 1'b1;
                end
            end
        end
        if (result_valid_o) begin
            if (waddr_i == result_waddr_o) hazard = 1'b1;
            for (int r = 0; r < 3; r++) begin
                if (read_regs_valid_i[r] && read_regs_i[r*WADDR +: WADDR] == result_waddr_o)
                    hazard = 1'b1;
            end
        end
    end

    assign full      = (cnt == CW'(DEPTH));
    assign apu_req_o = enable_i & ~hazard & ~full;
    assign stall_o   = enable_i & ~(apu_req_o & apu_gnt_i);
    assign push      = apu_req_o & apu_gnt_i;
    assign pop       = apu_rvalid_i & (cnt != '0);
    assign busy_o    = (cnt != '0) | result_valid_o;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt            <= '0;
            result_valid_o <= 1'b0;
            result_waddr_o <= '0;
            result_o       <= '0;
            flags_o        <= '0;
            proto_err_o    <= 1'b0;
        end else begin
            case ({push, pop})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
            result_valid_o <= pop;
            if (pop) begin
                result_waddr_o <= head_addr;
                result_o       <= apu_rdata_i;
                flags_o        <= apu_rflags_i;
            end
            if (apu_rvalid_i && cnt == '0) proto_err_o <= 1'b1;
        end
    end

`ifdef APU_DISPATCH_PERF_EN
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            perf_stall_cnt_o <= '0;
        end else if (stall_o && perf_stall_cnt_o != 16'hFFFF) begin
            perf_stall_cnt_o <= perf_stall_cnt_o + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_apu_core_dispatcher.sv
module tb_apu_core_dispatcher;

    localparam int WA = 6;
    localparam int WR = 32;
    localparam int NF = 8;

    logic              clk_i = 1'b0;
    logic              rst_i;
    logic              enable_i;
    logic [WA-1:0]     waddr_i;
    logic [3*WA-1:0]   read_regs_i;
    logic [2:0]        read_regs_valid_i;
    logic              apu_req_o;
    logic              apu_gnt_i;
    logic              apu_rvalid_i;
    logic [WR-1:0]     apu_rdata_i;
    logic [NF-1:0]     apu_rflags_i;
    logic              stall_o;
    logic              result_valid_o;
    logic [WA-1:0]     result_waddr_o;
    logic [WR-1:0]     result_o;
    logic [NF-1:0]     flags_o;
    logic              busy_o;
    logic              proto_err_o;
`ifdef APU_DISPATCH_PERF_EN
    logic [15:0]       perf_stall_cnt_o;
`endif

    always #5 clk_i = ~clk_i;

    apu_core_dispatcher #(.NUSFLAGS(NF), .WRESULT(WR), .WADDR(WA)) dut (
        .clk_i             (clk_i),
        .rst_i             (rst_i),
        .enable_i          (enable_i),
        .waddr_i           (waddr_i),
        .read_regs_i       (read_regs_i),
        .read_regs_valid_i (read_regs_valid_i),
        .apu_req_o         (apu_req_o),
        .apu_gnt_i         (apu_gnt_i),
        .apu_rvalid_i      (apu_rvalid_i),
        .apu_rdata_i       (apu_rdata_i),
        .apu_rflags_i      (apu_rflags_i),
        .stall_o           (stall_o),
        .result_valid_o    (result_valid_o),
        .result_waddr_o    (result_waddr_o),
        .result_o          (result_o),
        .flags_o           (flags_o),
        .busy_o            (busy_o),
        .proto_err_o       (proto_err_o)
`ifdef APU_DISPATCH_PERF_EN
        ,
        .perf_stall_cnt_o  (perf_stall_cnt_o)
`endif
    );

    typedef struct {
        logic [WA-1:0] waddr;
        logic [WR-1:0] data;
        logic [NF-1:0] flags;
    } wb_t;

    typedef struct {
        string         tag;
        logic          en;
        logic [WA-1:0] waddr;
        logic [3*WA-1:0] rr;
        logic [2:0]    rrv;
        logic          gnt;
        logic          rv;
        logic [WR-1:0] rdata;
        logic [NF-1:0] rflags;
        logic          exp_req;
        logic          exp_stall;
    } vec_t;

    int            total = 0;
    int            bad   = 0;
    wb_t           sb[$];
    logic [WA-1:0] inflight[$];
    logic          model_perr;
    wb_t           last_wb;
    int            perf_model;
    vec_t          vecs[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [3*WA-1:0] rr3(input logic [WA-1:0] a0, input logic [WA-1:0] a1,
                                            input logic [WA-1:0] a2);
        return {a2, a1, a0};
    endfunction

    function automatic vec_t mk(input string tag, input logic en, input logic [WA-1:0] wa,
                                input logic [3*WA-1:0] rr, input logic [2:0] rrv,
                                input logic gnt, input logic rv, input logic [WR-1:0] rd,
                                input logic [NF-1:0] rf, input logic er, input logic es);
        vec_t v;
        v.tag = tag; v.en = en; v.waddr = wa; v.rr = rr; v.rrv = rrv; v.gnt = gnt;
        v.rv = rv; v.rdata = rd; v.rflags = rf; v.exp_req = er; v.exp_stall = es;
        return v;
    endfunction

    // One clock cycle: drive, check the combinational handshake mid-cycle,
    // advance the reference queues at the edge, then check writeback/status.
    task automatic step(input vec_t v);
        logic wb_exp;
        wb_t  e;
        enable_i          = v.en;
        waddr_i           = v.waddr;
        read_regs_i       = v.rr;
        read_regs_valid_i = v.rrv;
        apu_gnt_i         = v.gnt;
        apu_rvalid_i      = v.rv;
        apu_rdata_i       = v.rdata;
        apu_rflags_i      = v.rflags;
        @(negedge clk_i);
        check({v.tag, " req"}, 64'(apu_req_o), 64'(v.exp_req));
        check({v.tag, " stall"}, 64'(stall_o), 64'(v.exp_stall));
        @(posedge clk_i);
        wb_exp = 1'b0;
        if (v.rv) begin
            if (inflight.size() > 0) begin
                e.waddr = inflight.pop_front();
                e.data  = v.rdata;
                e.flags = v.rflags;
                sb.push_back(e);
                wb_exp = 1'b1;
            end else begin
                model_perr = 1'b1;
            end
        end
        if (v.exp_req && v.gnt) inflight.push_back(v.waddr);
        if (v.exp_stall && perf_model < 65535) perf_model++;
        #1;
        check({v.tag, " result_valid"}, 64'(result_valid_o), 64'(wb_exp));
        if (result_valid_o) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL %s spurious writeback: got waddr %0h expected none", v.tag, result_waddr_o);
            end else begin
                e = sb.pop_front();
                check({v.tag, " wb waddr"}, 64'(result_waddr_o), 64'(e.waddr));
                check({v.tag, " wb data"}, 64'(result_o), 64'(e.data));
                check({v.tag, " wb flags"}, 64'(flags_o), 64'(e.flags));
                last_wb = e;
            end
        end else begin
            check({v.tag, " hold data"}, 64'(result_o), 64'(last_wb.data));
            check({v.tag, " hold waddr"}, 64'(result_waddr_o), 64'(last_wb.waddr));
        end
        if (sb.size() != 0) begin
            total++;
            bad++;
            $display("FAIL %s missing writeback: got none expected %0d pending", v.tag, sb.size());
            sb.delete();
        end
        check({v.tag, " busy"}, 64'(busy_o), 64'((inflight.size() != 0) || wb_exp));
        check({v.tag, " proto_err"}, 64'(proto_err_o), 64'(model_perr));
    endtask

    task automatic do_reset(input string tag);
        rst_i             = 1'b1;
        enable_i          = 1'b0;
        waddr_i           = '0;
        read_regs_i       = '0;
        read_regs_valid_i = '0;
        apu_gnt_i         = 1'b0;
        apu_rvalid_i      = 1'b0;
        apu_rdata_i       = '0;
        apu_rflags_i      = '0;
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        inflight.delete();
        sb.delete();
        model_perr = 1'b0;
        last_wb    = '{default: '0};
        perf_model = 0;
        check({tag, " rst result_valid"}, 64'(result_valid_o), 64'd0);
        check({tag, " rst waddr"}, 64'(result_waddr_o), 64'd0);
        check({tag, " rst data"}, 64'(result_o), 64'd0);
        check({tag, " rst flags"}, 64'(flags_o), 64'd0);
        check({tag, " rst busy"}, 64'(busy_o), 64'd0);
        check({tag, " rst proto_err"}, 64'(proto_err_o), 64'd0);
`ifdef APU_DISPATCH_PERF_EN
        check({tag, " rst perf"}, 64'(perf_stall_cnt_o), 64'd0);
`endif
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // single op, wb hazard on destination, full, RAW, src valid masking, push+pop
        vecs.push_back(mk("idle0",   0,  0, '0, 3'b000, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk("op5",     1,  5, '0, 3'b000, 1, 0, 0, 0, 1, 0));
        vecs.push_back(mk("wait1",   0,  0, '0, 3'b000, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk("wait2",   0,  0, '0, 3'b000, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk("rv5",     0,  0, '0, 3'b000, 0, 1, 32'h3F800000, 8'h01, 0, 0));
        vecs.push_back(mk("waw_wb",  1,  5, '0, 3'b000, 1, 0, 0, 0, 0, 1));
        vecs.push_back(mk("op5b",    1,  5, '0, 3'b000, 1, 0, 0, 0, 1, 0));
        vecs.push_back(mk("rv5b",    0,  0, '0, 3'b000, 0, 1, 32'hA5A5_0001, 8'h02, 0, 0));
        vecs.push_back(mk("idle1",   0,  0, '0, 3'b000, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk("op1",     1,  1, '0, 3'b000, 1, 0, 0, 0, 1, 0));
        vecs.push_back(mk("op2",     1,  2, '0, 3'b000, 1, 0, 0, 0, 1, 0));
        vecs.push_back(mk("full_a",  1,  3, '0, 3'b000, 1, 0, 0, 0, 0, 1));
        vecs.push_back(mk("full_rv", 1,  3, '0, 3'b000, 1, 1, 32'h0000_00B1, 8'h11, 0, 1));
        vecs.push_back(mk("op3",     1,  3, '0, 3'b000, 1, 0, 0, 0, 1, 0));
        vecs.push_back(mk("rv2",     0,  0, '0, 3'b000, 0, 1, 32'h0000_00C2, 8'h22, 0, 0));
        vecs.push_back(mk("rv3",     0,  0, '0, 3'b000, 0, 1, 32'h0000_00D3, 8'h33, 0, 0));
        vecs.push_back(mk("idle2",   0,  0, '0, 3'b000, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk("op7",     1,  7, '0, 3'b000, 1, 0, 0, 0, 1, 0));
        vecs.push_back(mk("raw_a",   1,  9, rr3(7, 0, 0), 3'b001, 1, 0, 0, 0, 0, 1));
        vecs.push_back(mk("raw_rv",  1,  9, rr3(7, 0, 0), 3'b001, 1, 1, 32'h0000_00E7, 8'h44, 0, 1));
        vecs.push_back(mk("raw_wb",  1,  9, rr3(7, 0, 0), 3'b001, 1, 0, 0, 0, 0, 1));
        vecs.push_back(mk("raw_go",  1,  9, rr3(7, 0, 0), 3'b001, 1, 0, 0, 0, 1, 0));
        vecs.push_back(mk("rv9",     0,  0, '0, 3'b000, 0, 1, 32'h0000_00F9, 8'h55, 0, 0));
        vecs.push_back(mk("idle3",   0,  0, '0, 3'b000, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk("op11",    1, 11, '0, 3'b000, 1, 0, 0, 0, 1, 0));
        vecs.push_back(mk("mask",    1, 12, rr3(0, 0, 11), 3'b011, 1, 0, 0, 0, 1, 0));
        vecs.push_back(mk("rv11",    0,  0, '0, 3'b000, 0, 1, 32'h1111_0011, 8'h66, 0, 0));
        vecs.push_back(mk("raw_s2",  1, 13, rr3(0, 0, 12), 3'b100, 1, 0, 0, 0, 0, 1));
        vecs.push_back(mk("rv12",    0,  0, '0, 3'b000, 0, 1, 32'h1212_0012, 8'h77, 0, 0));
        vecs.push_back(mk("idle4",   0,  0, '0, 3'b000, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk("idle5",   0,  0, '0, 3'b000, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk("op20",    1, 20, '0, 3'b000, 1, 0, 0, 0, 1, 0));
        vecs.push_back(mk("simul",   1, 21, '0, 3'b000, 1, 1, 32'h2020_0020, 8'h88, 1, 0));
        vecs.push_back(mk("rv21",    0,  0, '0, 3'b000, 0, 1, 32'h2121_0021, 8'h99, 0, 0));
        vecs.push_back(mk("idle6",   0,  0, '0, 3'b000, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk("nognt",   1,  4, '0, 3'b000, 0, 0, 0, 0, 1, 1));
        vecs.push_back(mk("gnt4",    1,  4, '0, 3'b000, 1, 0, 0, 0, 1, 0));
        vecs.push_back(mk("rv4",     0,  0, '0, 3'b000, 0, 1, 32'h0404_0404, 8'hAA, 0, 0));
        vecs.push_back(mk("idle7",   0,  0, '0, 3'b000, 0, 0, 0, 0, 0, 0));

        do_reset("init");

`ifdef APU_DISPATCH_PERF_EN
        for (int i = 0; i < 5; i++) step(mk("perf5", 1, 40, '0, 3'b000, 0, 0, 0, 0, 1, 1));
        check("perf five stalls", 64'(perf_stall_cnt_o), 64'd5);
`endif

        for (int i = 0; i < vecs.size(); i++) step(vecs[i]);

        // rvalid with nothing outstanding: no writeback, sticky error
        step(mk("perr",      0, 0, '0, 3'b000, 0, 1, 32'hDEAD_BEEF, 8'hFF, 0, 0));
        step(mk("perr_hold", 0, 0, '0, 3'b000, 0, 0, 0, 0, 0, 0));

        // op in flight is discarded by reset; its late rvalid is a protocol error
        step(mk("op30",      1, 30, '0, 3'b000, 1, 0, 0, 0, 1, 0));
        do_reset("mid");
        step(mk("late_rv",   0, 0, '0, 3'b000, 0, 1, 32'h3030_3030, 8'h30, 0, 0));
        do_reset("clr");
        step(mk("op31",      1, 31, '0, 3'b000, 1, 0, 0, 0, 1, 0));
        step(mk("rv31",      0, 0, '0, 3'b000, 0, 1, 32'h3131_3131, 8'h31, 0, 0));
        step(mk("idle8",     0, 0, '0, 3'b000, 0, 0, 0, 0, 0, 0));

`ifdef APU_DISPATCH_PERF_EN
        check("perf model", 64'(perf_stall_cnt_o), 64'(perf_model));
        enable_i  = 1'b1;
        waddr_i   = 6'd50;
        apu_gnt_i = 1'b0;
        repeat (65540) @(posedge clk_i);
        #1;
        check("perf saturate", 64'(perf_stall_cnt_o), 64'hFFFF);
        enable_i = 1'b0;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
